// File: rtl/xentry_types.sv
// xentry_types: shared memory-operation and L2 arbiter type definitions
//   memory_operation_e : operation carried on an L2 request (MEM_NONE idles the bus)
//   l2_arb_state_e     : arbiter FSM states
//   l2_requester_e     : which cache owns the L2 port
package xentry_types;
    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} memory_operation_e;
    typedef enum logic {ARB_IDLE, ARB_GRANT} l2_arb_state_e;
    typedef enum logic {REQ_ICACHE, REQ_DCACHE} l2_requester_e;
endpackage

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares one L2 request port between icache and dcache, one
// transaction at a time, round-robin with a bounded per-requester lock.
//   clk, reset (sync, active-low)
//   ic_* / dc_* : request address/type/valid/lock/store data in; fetched word and
//                 completion pulse out (zero for the non-owner)
//   l2_*        : muxed request out; fetched word and completion pulse in
//   l2_owner    : current or last owner (0 = icache, 1 = dcache)
module l2_port_arbiter
    import xentry_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    input  logic              ic_req_lock,
    input  logic [XLEN-1:0]   ic_word_to_store,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,
    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic              dc_req_lock,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,
    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled,
    output logic              l2_owner
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    l2_arb_state_e state, state_n;
    l2_requester_e owner, owner_n, last_owner, last_owner_n, pick;
    logic          locked, locked_n;
    logic [CW-1:0] lock_count, lock_count_n;
    logic          dc_sel, owner_valid, owner_lock, hold, grant, done;

    assign dc_sel      = owner == REQ_DCACHE;
    assign owner_valid = dc_sel ? dc_req_valid : ic_req_valid;
    assign owner_lock  = dc_sel ? dc_req_lock : ic_req_lock;
    assign hold        = locked && owner_valid;
    // Outputs are gated by reset so nothing leaks while reset is held low,
    // including a completion that arrives during reset.
    assign grant       = reset && state == ARB_GRANT;
    assign done        = grant && l2_req_fulfilled;
    assign pick        = hold ? owner :
                         (ic_req_valid && dc_req_valid) ?
                             (last_owner == REQ_ICACHE ? REQ_DCACHE : REQ_ICACHE) :
                         dc_req_valid ? REQ_DCACHE : REQ_ICACHE;

    assign l2_req_valid     = grant;
    assign l2_req_address   = grant ? (dc_sel ? dc_req_address : ic_req_address) : '0;
    assign l2_req_type      = grant ? (dc_sel ? dc_req_type : ic_req_type) : MEM_NONE;
    assign l2_word_to_store = grant ? (dc_sel ? dc_word_to_store : ic_word_to_store) : '0;
    assign ic_req_fulfilled = done && !dc_sel;
    assign dc_req_fulfilled = done && dc_sel;
    assign ic_fetched_word  = ic_req_fulfilled ? l2_fetched_word : '0;
    assign dc_fetched_word  = dc_req_fulfilled ? l2_fetched_word : '0;
    assign l2_owner         = reset && dc_sel;

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        locked_n     = locked;
        lock_count_n = lock_count;
        if (state == ARB_IDLE) begin
            // A lock whose owner has nothing pending is released before arbitrating.
            if (locked && !owner_valid) begin
                locked_n     = 1'b0;
                lock_count_n = '0;
            end
            if (hold || ic_req_valid || dc_req_valid) begin
                state_n = ARB_GRANT;
                owner_n = pick;
            end
        end else if (l2_req_fulfilled) begin
            state_n      = ARB_IDLE;
            last_owner_n = owner;
            if (owner_lock && (int'(lock_count) + 1 < MAX_LOCK)) begin
                locked_n     = 1'b1;
                lock_count_n = lock_count + 1'b1;
            end else begin
                locked_n     = 1'b0;
                lock_count_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= REQ_ICACHE;
            last_owner <= REQ_ICACHE;
            locked     <= 1'b0;
            lock_count <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            locked     <= locked_n;
            lock_count <= lock_count_n;
        end
    end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed and randomized checks of l2_port_arbiter against a behavioural model
module tb_l2_port_arbiter;
    import xentry_types::*;
    localparam int XLEN = 32;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic reset;
    logic [XLEN-1:0] ic_req_address, ic_word_to_store, ic_fetched_word;
    logic [XLEN-1:0] dc_req_address, dc_word_to_store, dc_fetched_word;
    logic [XLEN-1:0] l2_req_address, l2_word_to_store, l2_fetched_word;
    memory_operation_e ic_req_type, dc_req_type, l2_req_type;
    logic ic_req_valid, ic_req_lock, ic_req_fulfilled;
    logic dc_req_valid, dc_req_lock, dc_req_fulfilled;
    logic l2_req_valid, l2_req_fulfilled, l2_owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l2_port_arbiter #(.XLEN(XLEN), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .ic_req_address(ic_req_address), .ic_req_type(ic_req_type), .ic_req_valid(ic_req_valid),
        .ic_req_lock(ic_req_lock), .ic_word_to_store(ic_word_to_store),
        .ic_fetched_word(ic_fetched_word), .ic_req_fulfilled(ic_req_fulfilled),
        .dc_req_address(dc_req_address), .dc_req_type(dc_req_type), .dc_req_valid(dc_req_valid),
        .dc_req_lock(dc_req_lock), .dc_word_to_store(dc_word_to_store),
        .dc_fetched_word(dc_fetched_word), .dc_req_fulfilled(dc_req_fulfilled),
        .l2_req_address(l2_req_address), .l2_req_type(l2_req_type), .l2_req_valid(l2_req_valid),
        .l2_word_to_store(l2_word_to_store), .l2_fetched_word(l2_fetched_word),
        .l2_req_fulfilled(l2_req_fulfilled), .l2_owner(l2_owner)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: who is being served, who was served last, and how many
    // consecutive locked re-grants the current holder has already used.
    bit m_busy = 0, m_hold = 0;
    int m_owner = 0, m_last = 0, m_streak = 0, w;
    logic ev, eo, efi, efd;
    logic [XLEN-1:0] ea, ew, ewi, ewd;
    memory_operation_e et;

    always @(negedge clk) begin
        ev = 0; eo = 0; ea = 0; ew = 0; et = MEM_NONE; efi = 0; efd = 0; ewi = 0; ewd = 0;
        if (!reset) begin
            m_busy = 0; m_hold = 0; m_owner = 0; m_last = 0; m_streak = 0;
        end else if (m_busy) begin
            ev = 1;
            eo = (m_owner == 1);
            ea = m_owner == 1 ? dc_req_address : ic_req_address;
            et = m_owner == 1 ? dc_req_type : ic_req_type;
            ew = m_owner == 1 ? dc_word_to_store : ic_word_to_store;
            efi = l2_req_fulfilled && m_owner == 0;
            efd = l2_req_fulfilled && m_owner == 1;
            ewi = efi ? l2_fetched_word : 0;
            ewd = efd ? l2_fetched_word : 0;
            if (l2_req_fulfilled) begin
                m_busy = 0;
                m_last = m_owner;
                if ((m_owner == 1 ? dc_req_lock : ic_req_lock) && m_streak + 1 < MAX_LOCK) begin
                    m_hold = 1;
                    m_streak++;
                end else begin
                    m_hold = 0;
                    m_streak = 0;
                end
            end
        end else begin
            eo = (m_owner == 1);
            if (m_hold && !(m_owner == 1 ? dc_req_valid : ic_req_valid)) begin
                m_hold = 0;
                m_streak = 0;
            end
            w = m_hold ? m_owner : (ic_req_valid && dc_req_valid) ? 1 - m_last :
                dc_req_valid ? 1 : ic_req_valid ? 0 : -1;
            if (w >= 0) begin
                m_busy = 1;
                m_owner = w;
            end
        end
        chk("l2_req_valid", l2_req_valid, ev);
        chk("l2_owner", l2_owner, eo);
        chk("l2_req_address", l2_req_address, ea);
        chk("l2_req_type", l2_req_type, et);
        chk("l2_word_to_store", l2_word_to_store, ew);
        chk("ic_req_fulfilled", ic_req_fulfilled, efi);
        chk("dc_req_fulfilled", dc_req_fulfilled, efd);
        chk("ic_fetched_word", ic_fetched_word, ewi);
        chk("dc_fetched_word", dc_fetched_word, ewd);
    end

    int owners[$];
    logic s_icf, s_dcf;
    logic [XLEN-1:0] s_icw, s_dcw;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int lat, input logic [XLEN-1:0] data);
        int n;
        n = 0;
        tick;
        while (!l2_req_valid && n < 20) begin
            tick;
            n++;
        end
        if (n >= 20) chk("serve_timeout", 1, 0);
        repeat (lat) tick;
        l2_req_fulfilled = 1;
        l2_fetched_word = data;
        @(negedge clk);
        owners.push_back(int'(l2_owner));
        s_icf = ic_req_fulfilled; s_icw = ic_fetched_word;
        s_dcf = dc_req_fulfilled; s_dcw = dc_fetched_word;
        tick;
        l2_req_fulfilled = 0;
    endtask

    initial begin
        int alt[4];
        int lk[6];
        int lat;
        bit icd, dcd, lv;
        alt = '{1, 0, 1, 0};
        lk = '{1, 1, 1, 1, 0, 1};
        reset = 0;
        ic_req_address = 32'h100; ic_req_type = MEM_LOAD; ic_req_valid = 1; ic_req_lock = 0; ic_word_to_store = 0;
        dc_req_address = 0; dc_req_type = MEM_NONE; dc_req_valid = 0; dc_req_lock = 0; dc_word_to_store = 0;
        l2_fetched_word = 0; l2_req_fulfilled = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_l2_req_valid", l2_req_valid, 0);
            chk("rst_l2_owner", l2_owner, 0);
            chk("rst_l2_req_address", l2_req_address, 0);
        end
        tick;
        reset = 1;
        @(negedge clk);
        chk("grant_latency_n", l2_req_valid, 0);
        tick;
        chk("grant_latency_n1", l2_req_valid, 1);
        chk("grant_address", l2_req_address, 32'h100);
        serve(0, 32'h1234);
        ic_req_valid = 0;
        tick;

        ic_req_address = 32'h40; ic_req_valid = 1;
        serve(3, 32'hDEADBEEF);
        chk("ic_read_fulfilled", s_icf, 1);
        chk("ic_read_word", s_icw, 32'hDEADBEEF);
        chk("ic_read_dc_word", s_dcw, 0);
        chk("ic_read_dc_fulfilled", s_dcf, 0);
        ic_req_valid = 0;
        @(negedge clk);
        chk("ic_pulse_width", ic_req_fulfilled, 0);
        tick;

        owners.delete();
        ic_req_valid = 1; dc_req_valid = 1; dc_req_address = 32'h200; dc_req_type = MEM_STORE; dc_word_to_store = 32'hCAFE;
        repeat (4) serve(1, $urandom);
        for (int i = 0; i < 4; i++) chk("alternate_owner", owners[i], alt[i]);
        ic_req_valid = 0; dc_req_valid = 0;
        tick;

        owners.delete();
        ic_req_valid = 1; dc_req_valid = 1; dc_req_lock = 1;
        repeat (6) serve(0, $urandom);
        for (int i = 0; i < 6; i++) chk("lock_owner", owners[i], lk[i]);
        dc_req_valid = 0; dc_req_lock = 0;
        @(negedge clk);
        chk("lock_drop_idle", l2_req_valid, 0);
        tick;
        chk("lock_drop_grant", l2_req_valid, 1);
        chk("lock_drop_owner", l2_owner, 0);
        serve(1, $urandom);
        ic_req_valid = 0;
        tick;

        dc_req_valid = 1;
        tick;
        for (int i = 0; i < 20 && !l2_req_valid; i++) tick;
        chk("midgrant_started", l2_req_valid, 1);
        tick;
        reset = 0;
        @(negedge clk);
        chk("midgrant_reset_valid", l2_req_valid, 0);
        tick;
        reset = 1; dc_req_valid = 0; l2_req_fulfilled = 1; l2_fetched_word = 32'h5555;
        @(negedge clk);
        chk("stray_dc_fulfilled", dc_req_fulfilled, 0);
        chk("stray_ic_fulfilled", ic_req_fulfilled, 0);
        chk("stray_dc_word", dc_fetched_word, 0);
        tick;
        l2_req_fulfilled = 0;
        @(negedge clk);
        chk("stray_idle", l2_req_valid, 0);

        lat = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            icd = ic_req_fulfilled; dcd = dc_req_fulfilled; lv = l2_req_valid;
            @(posedge clk);
            #1;
            reset = (i >= 3970) || ($urandom_range(0, 299) != 0);
            if (l2_req_fulfilled) l2_req_fulfilled = 0;
            else if (lv) begin
                if (lat == 0) begin
                    l2_req_fulfilled = 1;
                    l2_fetched_word = $urandom;
                    lat = $urandom_range(0, 3);
                end else lat--;
            end else if ($urandom_range(0, 19) == 0) begin
                l2_req_fulfilled = 1;
                l2_fetched_word = $urandom;
            end
            if (!ic_req_valid || icd) begin
                ic_req_valid = (i < 3970) && ($urandom_range(0, 2) != 0);
                ic_req_address = $urandom; ic_word_to_store = $urandom;
                ic_req_type = memory_operation_e'($urandom_range(1, 2));
                ic_req_lock = 1'($urandom_range(0, 1));
            end
            if (!dc_req_valid || dcd) begin
                dc_req_valid = (i < 3970) && ($urandom_range(0, 2) != 0);
                dc_req_address = $urandom; dc_word_to_store = $urandom;
                dc_req_type = memory_operation_e'($urandom_range(1, 2));
                dc_req_lock = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
